dp_div_arbiter: RTL and testbench



---
 rtl/dp_div_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dp_div_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_div_arbiter.sv
// Round-robin arbiter in front of one shared iterative restoring divider.
// One requester is served at a time; results return with a done pulse tagged by requester ID.
module dp_div_arbiter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dividend,
    input  logic [NREQ*WIDTH-1:0] divisor,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [WIDTH-1:0]      quot,
    output logic [WIDTH-1:0]      rem,
    output logic                  div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Dividend shifts out MSB-first while quotient bits shift into its LSB.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [IDW-1:0]   win;
    logic             found;
    logic [IDW-1:0]   idx;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_quot;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr_q + IDW'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        shifted   = {prem_q, dvd_q[WIDTH-1]};
        ge        = shifted >= {1'b0, dvs_q};
        // When ge holds the true difference is below 2^WIDTH, so WIDTH bits suffice.
        diff      = shifted[WIDTH-1:0] - dvs_q;
        next_rem  = ge ? diff : shifted[WIDTH-1:0];
        next_quot = {dvd_q[WIDTH-2:0], ge};
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        done_id_d = done_id_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    id_d    = win;
                    dvd_d   = dividend[int'(win)*WIDTH +: WIDTH];
                    dvs_d   = divisor[int'(win)*WIDTH +: WIDTH];
                    prem_d  = '0;
                    cnt_d   = '0;
                    gnt_d   = NREQ'(1) << win;
                    busy_d  = 1'b1;
                    ptr_d   = win + 1'b1;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                if (dvs_q == '0) begin
                    quot_d    = '1;
                    rem_d     = dvd_q;
                    dbz_d     = 1'b1;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    state_d   = StDone;
                end else begin
                    prem_d = next_rem;
                    dvd_d  = next_quot;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        quot_d    = next_quot;
                        rem_d     = next_rem;
                        dbz_d     = 1'b0;
                        done_d    = 1'b1;
                        done_id_d = id_q;
                        cnt_d     = '0;
                        state_d   = StDone;
                    end
                end
            end
            StDone: begin
                done_d  = 1'b0;
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign gnt         = gnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_dp_div_arbiter.sv
// Bench for dp_div_arbiter: directed scenarios plus random traffic, checked every cycle
// against a countdown/queue-level model of arbitration and unsigned division.
module tb_dp_div_arbiter;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*W-1:0]    dividend;
    logic [N*W-1:0]    divisor;
    logic [N-1:0]      gnt;
    logic              busy;
    logic              done;
    logic [IW-1:0]     done_id;
    logic [W-1:0]      quot;
    logic [W-1:0]      rem;
    logic              div_by_zero;

    dp_div_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .dividend   (dividend),
        .divisor    (divisor),
        .gnt        (gnt),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .quot       (quot),
        .rem        (rem),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    int          m_ptr, m_own, m_left, w_now;
    bit          m_run, m_dn;
    logic [W-1:0] m_a, m_b;
    logic [N-1:0] e_gnt;
    logic        e_busy, e_done, e_z;
    logic [IW-1:0] e_id;
    logic [W-1:0] e_q, e_r;

    assign w_now = pick(req, m_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr <= 0; m_own <= 0; m_left <= 0; m_run <= 0; m_dn <= 0;
            m_a <= '0; m_b <= '0;
            e_gnt <= '0; e_busy <= 0; e_done <= 0; e_z <= 0; e_id <= '0; e_q <= '0; e_r <= '0;
        end else if (m_dn) begin
            m_dn <= 0; e_done <= 0; e_gnt <= '0; e_busy <= 0;
        end else if (m_run) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_run  <= 0;
                m_dn   <= 1;
                e_done <= 1;
                e_id   <= IW'(m_own);
                e_z    <= (m_b == 0);
                e_q    <= (m_b == 0) ? {W{1'b1}} : m_a / m_b;
                e_r    <= (m_b == 0) ? m_a : m_a % m_b;
            end
        end else if (req != '0) begin
            m_own  <= w_now;
            m_a    <= dividend[w_now*W +: W];
            m_b    <= divisor[w_now*W +: W];
            m_left <= (divisor[w_now*W +: W] == 0) ? 1 : W;
            m_run  <= 1;
            m_ptr  <= (w_now + 1) % N;
            e_gnt  <= N'(1) << w_now;
            e_busy <= 1;
        end
    end

    always @(negedge clk) begin
        chk("gnt", W'(gnt), W'(e_gnt));
        chk("busy", W'(busy), W'(e_busy));
        chk("done", W'(done), W'(e_done));
        chk("done_id", W'(done_id), W'(e_id));
        chk("quot", quot, e_q);
        chk("rem", rem, e_r);
        chk("div_by_zero", W'(div_by_zero), W'(e_z));
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        dividend[i*W +: W] = a;
        divisor[i*W +: W]  = b;
    endtask

    // Each requester drops req in the cycle it sees its own done.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) if (done && done_id == IW'(i)) req[i] = 1'b0;
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (done) begin
                t = cyc;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL wait_done: timeout got no done expected done within 300 cycles");
    endtask

    task automatic expect_res(input string name, input int id, input logic [W-1:0] q,
                              input logic [W-1:0] r, input logic z);
        chk({name, "_id"}, W'(done_id), W'(id));
        chk({name, "_quot"}, quot, q);
        chk({name, "_rem"}, rem, r);
        chk({name, "_dbz"}, W'(div_by_zero), W'(z));
    endtask

    int t, t_prev, t_set;
    bit seen;
    logic [W-1:0] ra, rb;

    initial begin
        rst = 1'b1;
        req = '0;
        dividend = '0;
        divisor = '0;
        set_op(0, 100, 10);
        set_op(1, 100, 8);
        set_op(2, 8, 4);
        set_op(3, 1, 1);
        req = 4'b1111;
        repeat (2) @(negedge clk);
        chk("rst_gnt", W'(gnt), 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_quot", quot, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_gnt", W'(gnt), W'(4'b0001));

        // Contention: round-robin order 0..3, 66 cycles apart.
        t_prev = 0;
        for (int n = 0; n < 4; n++) begin
            wait_done(t);
            case (n)
                0: expect_res("cont0", 0, 10, 0, 0);
                1: expect_res("cont1", 1, 12, 4, 0);
                2: expect_res("cont2", 2, 2, 0, 0);
                default: expect_res("cont3", 3, 1, 0, 0);
            endcase
            if (n > 0) chk("cont_spacing", W'(t - t_prev), 66);
            t_prev = t;
        end

        // Single request latency: grant edge is one cycle after t_set.
        tick();
        set_op(0, 100, 10);
        req[0] = 1'b1;
        t_set = cyc;
        wait_done(t);
        expect_res("single", 0, 10, 0, 0);
        chk("single_latency", W'(t - t_set), 65);
        tick();
        set_op(0, 1, 1);
        req[0] = 1'b1;
        wait_done(t);
        expect_res("one", 0, 1, 0, 0);

        tick();
        set_op(1, 8, 0);
        req[1] = 1'b1;
        t_set = cyc;
        wait_done(t);
        expect_res("dbz", 1, {W{1'b1}}, 8, 1);
        chk("dbz_latency", W'(t - t_set), 2);

        // Rotation: after ID 2, requesters 1 and 3 together -> 3 first.
        tick();
        set_op(2, 7, 2);
        req[2] = 1'b1;
        wait_done(t);
        expect_res("rot2", 2, 3, 1, 0);
        tick();
        set_op(1, 50, 7);
        set_op(3, 9, 3);
        req[1] = 1'b1;
        req[3] = 1'b1;
        wait_done(t);
        expect_res("rot_first", 3, 3, 0, 0);
        wait_done(t);
        expect_res("rot_second", 1, 7, 1, 0);

        // Reset 30 cycles into a division.
        tick();
        set_op(0, 1000, 3);
        req[0] = 1'b1;
        tick();
        repeat (30) tick();
        chk("pre_rst_busy", W'(busy), 1);
        rst = 1'b1;
        req = '0;
        #1;
        chk("midrst_gnt", W'(gnt), 0);
        chk("midrst_busy", W'(busy), 0);
        chk("midrst_quot", quot, 0);
        chk("midrst_rem", rem, 0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (done) seen = 1;
        end
        chk("no_done_after_rst", W'(seen), 0);

        set_op(2, {W{1'b1}}, 1);
        req[2] = 1'b1;
        wait_done(t);
        expect_res("allones", 2, {W{1'b1}}, 0, 0);
        tick();
        set_op(2, 3, 5);
        req[2] = 1'b1;
        wait_done(t);
        expect_res("small", 2, 0, 3, 0);

        // Random traffic; the per-cycle compare does the checking.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    set_op(i, {$urandom, $urandom}, {$urandom, $urandom});
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    ra = {$urandom, $urandom};
                    case ($urandom_range(0, 7))
                        0: rb = '0;
                        1, 2: rb = W'($urandom_range(1, 15));
                        3: rb = ra;
                        4: rb = W'($urandom);
                        default: rb = {$urandom, $urandom} >> $urandom_range(0, 63);
                    endcase
                    if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 100));
                    set_op(i, ra, rb);
                    req[i] = 1'b1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
